// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer read arbiter.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DECODE,
    DONE
  } fb_state_t;

  typedef enum logic {
    OWN_DISP,
    OWN_AVG
  } fb_owner_t;

  localparam int unsigned FB_W = 480;
  localparam int unsigned FB_H = 480;

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid + tag shift register that tracks BRAM reads for a fixed read latency.
module rd_tag_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_tag,
  output logic         o_valid,
  output logic [W-1:0] o_tag
);

  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_tag [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_tag[i] <= '0;
    end else begin
      r_valid[0] <= i_push;
      r_tag[0]   <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Frame buffer port B arbiter: sequences capture/decode/display and routes
// each returned pixel to the owner that issued the read.
module fb_read_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DEPTH        = 230400,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned TIMEOUT      = 2000000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              capture_in,
  input  logic              decode_start_in,
  input  logic              avg_done_in,
  input  logic [ADDR_W-1:0] disp_addr_in,
  input  logic              disp_valid_in,
  input  logic              avg_req_in,
  input  logic [ADDR_W-1:0] avg_addr_in,
  input  logic              bram_dout_in,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic              bram_en_out,
  output logic              fb_wr_en_out,
  output logic              avg_start_out,
  output logic              avg_gnt_out,
  output logic              avg_pixel_out,
  output logic              avg_pixel_valid_out,
  output logic              disp_pixel_out,
  output logic              disp_pixel_valid_out,
  output logic [1:0]        state_out,
  output logic              timeout_err_out
);

  localparam int unsigned       CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] W_DEPTH = ADDR_W'(DEPTH);

  fb_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_avg_start, r_timeout_err;
  logic             w_enter_decode, w_timeout_exit, w_timeout_hit;
  logic             w_disp_inr, w_avg_inr;
  logic             w_push, w_blank_push;
  logic [1:0]       w_tag, w_rd_tag, w_bl_tag;
  logic             w_rd_valid, w_bl_valid;
  logic             w_rd_disp, w_rd_avg, w_bl_disp;

  assign w_disp_inr    = disp_addr_in < W_DEPTH;
  assign w_avg_inr     = avg_addr_in < W_DEPTH;
  assign w_timeout_hit = r_cnt == CNT_W'(TIMEOUT - 1);

  always_comb begin
    w_state_nxt    = r_state;
    w_enter_decode = 1'b0;
    w_timeout_exit = 1'b0;
    case (r_state)
      IDLE:   w_state_nxt = STREAM;
      STREAM: if (capture_in && decode_start_in) begin
        w_state_nxt    = DECODE;
        w_enter_decode = 1'b1;
      end
      DECODE: begin
        // Abort beats done, done beats timeout.
        if (!capture_in)      w_state_nxt = STREAM;
        else if (avg_done_in) w_state_nxt = DONE;
        else if (w_timeout_hit) begin
          w_state_nxt    = DONE;
          w_timeout_exit = 1'b1;
        end
      end
      DONE:    if (!decode_start_in) w_state_nxt = STREAM;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_avg_start   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_avg_start <= w_enter_decode;
      if (w_enter_decode)        r_cnt <= '0;
      else if (r_state == DECODE) r_cnt <= r_cnt + CNT_W'(1);
      if (w_enter_decode)      r_timeout_err <= 1'b0;
      else if (w_timeout_exit) r_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    bram_addr_out = '0;
    bram_en_out   = 1'b0;
    avg_gnt_out   = 1'b0;
    w_push        = 1'b0;
    w_tag         = '0;
    w_blank_push  = 1'b0;
    case (r_state)
      STREAM, DONE: begin
        bram_addr_out = disp_addr_in;
        bram_en_out   = disp_valid_in && w_disp_inr;
        w_push        = disp_valid_in;
        w_tag         = {OWN_DISP, w_disp_inr};
      end
      DECODE: begin
        avg_gnt_out   = avg_req_in;
        bram_addr_out = avg_addr_in;
        bram_en_out   = avg_req_in && w_avg_inr;
        w_push        = avg_req_in;
        w_tag         = {OWN_AVG, w_avg_inr};
        w_blank_push  = disp_valid_in;
      end
      default: ;
    endcase
  end

  // Blanked display requests in DECODE can coincide with an avg grant, so
  // they ride a second pipe rather than competing for the read pipe slot.
  rd_tag_pipe #(.DEPTH(READ_LATENCY), .W(2)) u_rd_pipe (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_push  (w_push),
    .i_tag   (w_tag),
    .o_valid (w_rd_valid),
    .o_tag   (w_rd_tag)
  );

  rd_tag_pipe #(.DEPTH(READ_LATENCY), .W(2)) u_blank_pipe (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_push  (w_blank_push),
    .i_tag   ({OWN_DISP, 1'b0}),
    .o_valid (w_bl_valid),
    .o_tag   (w_bl_tag)
  );

  assign w_rd_disp = w_rd_valid && (w_rd_tag[1] == OWN_DISP);
  assign w_rd_avg  = w_rd_valid && (w_rd_tag[1] == OWN_AVG);
  assign w_bl_disp = w_bl_valid && (w_bl_tag[1] == OWN_DISP);

  assign disp_pixel_valid_out = w_rd_disp || w_bl_disp;
  assign disp_pixel_out       = ((w_rd_disp && w_rd_tag[0]) || (w_bl_disp && w_bl_tag[0]))
                                && bram_dout_in;
  assign avg_pixel_valid_out  = w_rd_avg;
  assign avg_pixel_out        = w_rd_avg && w_rd_tag[0] && bram_dout_in;

  assign fb_wr_en_out    = (r_state == STREAM) && !capture_in;
  assign avg_start_out   = r_avg_start;
  assign timeout_err_out = r_timeout_err;
  assign state_out       = r_state;

endmodule
